// File: rtl/ps2_pkg.sv
// Shared action encoding and scancode constants for the PS/2 character buffer.
package ps2_pkg;

  typedef enum logic [2:0] {
    ActNone,
    ActPrint,
    ActBksp,
    ActEnter,
    ActCaps,
    ActClear
  } action_e;

  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_CAPS  = 8'h58;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_DEL   = 8'h71;

  localparam logic [7:0] BLANK_CHAR  = 8'h20;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational classifier: {prefix, scancode} release word to an edit action and ASCII char.
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [15:0] word,
  input  logic        caps,
  output action_e     action,
  output logic [7:0]  ch
);

  always_comb begin
    action = ActNone;
    ch     = 8'h00;
    if (word[15:8] == 8'h00) begin
      action = ActPrint;
      case (word[7:0])
        8'h1C: ch = 8'h61;
        8'h32: ch = 8'h62;
        8'h21: ch = 8'h63;
        8'h23: ch = 8'h64;
        8'h24: ch = 8'h65;
        8'h2B: ch = 8'h66;
        8'h34: ch = 8'h67;
        8'h33: ch = 8'h68;
        8'h43: ch = 8'h69;
        8'h3B: ch = 8'h6A;
        8'h42: ch = 8'h6B;
        8'h4B: ch = 8'h6C;
        8'h3A: ch = 8'h6D;
        8'h31: ch = 8'h6E;
        8'h44: ch = 8'h6F;
        8'h4D: ch = 8'h70;
        8'h15: ch = 8'h71;
        8'h2D: ch = 8'h72;
        8'h1B: ch = 8'h73;
        8'h2C: ch = 8'h74;
        8'h3C: ch = 8'h75;
        8'h2A: ch = 8'h76;
        8'h1D: ch = 8'h77;
        8'h22: ch = 8'h78;
        8'h35: ch = 8'h79;
        8'h1A: ch = 8'h7A;
        8'h45: ch = 8'h30;
        8'h16: ch = 8'h31;
        8'h1E: ch = 8'h32;
        8'h26: ch = 8'h33;
        8'h25: ch = 8'h34;
        8'h2E: ch = 8'h35;
        8'h36: ch = 8'h36;
        8'h3D: ch = 8'h37;
        8'h3E: ch = 8'h38;
        8'h46: ch = 8'h39;
        8'h29: ch = 8'h20;
        SC_BKSP:  action = ActBksp;
        SC_ENTER: action = ActEnter;
        SC_CAPS:  action = ActCaps;
        default:  action = ActNone;
      endcase
    end else if (word[15:8] == SC_EXT && word[7:0] == SC_DEL) begin
      action = ActClear;
    end

    // Only lowercase letters are shifted; digits and space ignore Caps.
    if (action == ActPrint && caps && ch >= 8'h61 && ch <= 8'h7A) begin
      ch = ch - CASE_OFFSET;
    end
  end

endmodule

// File: rtl/ps2_char_buffer.sv
// Three-stage PS/2 line editor: new-word detect, decode, execute into a 16-cell line buffer.
module ps2_char_buffer
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter logic [7:0]  BLANK  = BLANK_CHAR
) (
  input  logic              CLK_20M,
  input  logic              RST_N,
  input  logic [15:0]       i_ps2_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_char,
  output logic [ADDR_W:0]   o_cursor,
  output logic              o_caps,
  output logic              o_full,
  output logic              o_upd
);

  localparam logic [ADDR_W:0] CursorMax = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CursorOne = (ADDR_W + 1)'(1);

  logic [15:0]       prev_q, w1_q;
  logic              v1_q, v2_q;
  action_e           act2_q, dec_act;
  logic [7:0]        ch2_q, dec_ch;
  logic [ADDR_W:0]   cursor_q, cursor_d;
  logic              caps_q, caps_d;
  logic              upd_q, upd_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        rd_q;
  logic              wr_en, clr_all;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              new_word;

  assign new_word = (i_ps2_data != prev_q) && (i_ps2_data != 16'h0000);

  ps2_scan2ascii u_scan2ascii (
    .word   (w1_q),
    .caps   (caps_q),
    .action (dec_act),
    .ch     (dec_ch)
  );

  always_ff @(posedge CLK_20M or negedge RST_N) begin
    if (!RST_N) begin
      prev_q <= 16'h0000;
      w1_q   <= 16'h0000;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      act2_q <= ActNone;
      ch2_q  <= 8'h00;
    end else begin
      prev_q <= i_ps2_data;
      v1_q   <= new_word;
      if (new_word) w1_q <= i_ps2_data;
      v2_q   <= v1_q;
      act2_q <= dec_act;
      ch2_q  <= dec_ch;
    end
  end

  always_comb begin
    cursor_d = cursor_q;
    caps_d   = caps_q;
    upd_d    = 1'b0;
    wr_en    = 1'b0;
    clr_all  = 1'b0;
    wr_addr  = cursor_q[ADDR_W-1:0];
    wr_data  = ch2_q;
    if (v2_q) begin
      case (act2_q)
        ActPrint: begin
          if (cursor_q < CursorMax) begin
            wr_en    = 1'b1;
            cursor_d = cursor_q + CursorOne;
            upd_d    = 1'b1;
          end
        end
        ActBksp: begin
          if (cursor_q != '0) begin
            cursor_d = cursor_q - CursorOne;
            wr_en    = 1'b1;
            wr_addr  = cursor_d[ADDR_W-1:0];
            wr_data  = BLANK;
            upd_d    = 1'b1;
          end
        end
        ActEnter, ActClear: begin
          clr_all  = 1'b1;
          cursor_d = '0;
          upd_d    = 1'b1;
        end
        ActCaps: caps_d = ~caps_q;
        default: ;
      endcase
    end
    // Keys arrive far apart in practice; this only guards the pulse shape.
    upd_d = upd_d & ~upd_q;
  end

  always_ff @(posedge CLK_20M or negedge RST_N) begin
    if (!RST_N) begin
      cursor_q <= '0;
      caps_q   <= 1'b0;
      upd_q    <= 1'b0;
      rd_q     <= 8'h00;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= BLANK;
    end else begin
      cursor_q <= cursor_d;
      caps_q   <= caps_d;
      upd_q    <= upd_d;
      rd_q     <= mem_q[i_rd_addr];
      if (clr_all) begin
        for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= BLANK;
      end else if (wr_en) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  assign o_rd_char = rd_q;
  assign o_cursor  = cursor_q;
  assign o_caps    = caps_q;
  assign o_full    = (cursor_q == CursorMax);
  assign o_upd     = upd_q;

endmodule

// File: tb/tb_ps2_char_buffer.sv
// Randomised self-checking bench for ps2_char_buffer against a line-editor reference model.
module tb_ps2_char_buffer;

  logic        CLK_20M = 1'b0;
  logic        RST_N;
  logic [15:0] i_ps2_data;
  logic [3:0]  i_rd_addr;
  logic [7:0]  o_rd_char;
  logic [4:0]  o_cursor;
  logic        o_caps, o_full, o_upd;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mbuf [16];
  int          mcur;
  bit          mcaps;
  logic [15:0] mprev;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                   8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                   8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                   8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46};

  ps2_char_buffer dut (
    .CLK_20M    (CLK_20M),
    .RST_N      (RST_N),
    .i_ps2_data (i_ps2_data),
    .i_rd_addr  (i_rd_addr),
    .o_rd_char  (o_rd_char),
    .o_cursor   (o_cursor),
    .o_caps     (o_caps),
    .o_full     (o_full),
    .o_upd      (o_upd)
  );

  always #25 CLK_20M = ~CLK_20M;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mbuf[i] = 8'h20;
    mcur  = 0;
    mcaps = 0;
    mprev = 16'h0000;
  endfunction

  function automatic void model_key(input logic [15:0] w, output bit upd);
    int   kind = 0;  // 0 none, 1 print, 2 bksp, 3 clear, 4 caps
    logic [7:0] ch = 8'h00;
    upd = 0;
    if (w[15:8] == 8'h00) begin
      for (int i = 0; i < 26; i++)
        if (letter_codes[i] == w[7:0]) begin
          kind = 1;
          ch = (mcaps ? 8'h41 : 8'h61) + 8'(i);
        end
      for (int i = 0; i < 10; i++)
        if (digit_codes[i] == w[7:0]) begin kind = 1; ch = 8'h30 + 8'(i); end
      if (w[7:0] == 8'h29) begin kind = 1; ch = 8'h20; end
      if (w[7:0] == 8'h66) kind = 2;
      if (w[7:0] == 8'h5A) kind = 3;
      if (w[7:0] == 8'h58) kind = 4;
    end else if (w == 16'hE071) begin
      kind = 3;
    end
    case (kind)
      1: if (mcur < 16) begin mbuf[mcur] = ch; mcur++; upd = 1; end
      2: if (mcur > 0) begin mcur--; mbuf[mcur] = 8'h20; upd = 1; end
      3: begin for (int i = 0; i < 16; i++) mbuf[i] = 8'h20; mcur = 0; upd = 1; end
      4: mcaps = !mcaps;
      default: ;
    endcase
  endfunction

  task automatic send_word(input logic [15:0] w);
    bit trig, exp_upd;
    @(posedge CLK_20M); #1;
    i_ps2_data = w;
    trig = (w != mprev) && (w != 16'h0000);
    mprev = w;
    exp_upd = 0;
    if (trig) model_key(w, exp_upd);
    for (int c = 1; c <= 5; c++) begin
      @(posedge CLK_20M); #1;
      n_checks++;
      if (o_upd !== (exp_upd && c == 3)) begin
        n_fail++;
        $display("FAIL upd word=%h cycle=%0d: got %b expected %b", w, c, o_upd, exp_upd && c == 3);
      end
    end
    n_checks++;
    if (o_cursor !== 5'(mcur) || o_caps !== mcaps || o_full !== (mcur == 16)) begin
      n_fail++;
      $display("FAIL state word=%h: got cur=%0d caps=%b full=%b expected cur=%0d caps=%b full=%b",
               w, o_cursor, o_caps, o_full, mcur, mcaps, mcur == 16);
    end
  endtask

  task automatic check_buf(input string tag);
    for (int a = 0; a < 16; a++) begin
      i_rd_addr = 4'(a);
      @(posedge CLK_20M); #1;
      n_checks++;
      if (o_rd_char !== mbuf[a]) begin
        n_fail++;
        $display("FAIL buf %s [%0d]: got %h expected %h", tag, a, o_rd_char, mbuf[a]);
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 0;
    i_ps2_data = 16'h0000;
    i_rd_addr = 4'd0;
    model_reset();
    repeat (3) @(posedge CLK_20M);
    #1;
    n_checks++;
    if (o_rd_char !== 8'h00 || o_cursor !== 5'd0 || o_caps !== 1'b0 || o_full !== 1'b0 ||
        o_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset outputs: got rd=%h cur=%0d caps=%b full=%b upd=%b expected all zero",
               o_rd_char, o_cursor, o_caps, o_full, o_upd);
    end
    RST_N = 1;
    check_buf("reset");
  endtask

  task automatic test_print();
    send_word(16'h001C);
    send_word(16'h0032);
    check_buf("print");
    n_checks++;
    if (o_cursor !== 5'd2) begin
      n_fail++;
      $display("FAIL print cursor: got %0d expected 2", o_cursor);
    end
  endtask

  task automatic test_caps();
    send_word(16'hE071);
    send_word(16'h0058);
    send_word(16'h001C);
    check_buf("caps");
    n_checks++;
    if (o_rd_char !== 8'h20 || mbuf[0] !== 8'h41) begin
      n_fail++;
      $display("FAIL caps model/last cell: got %h/%h expected 20/41", o_rd_char, mbuf[0]);
    end
    send_word(16'h0058);
  endtask

  task automatic test_full();
    send_word(16'hE071);
    for (int i = 0; i < 16; i++) send_word((i % 2 == 0) ? 16'h0016 : 16'h001E);
    send_word(16'h0045);
    check_buf("full");
    n_checks++;
    if (o_full !== 1'b1 || o_rd_char !== 8'h32) begin
      n_fail++;
      $display("FAIL full: got full=%b buf15=%h expected 1/32", o_full, o_rd_char);
    end
  endtask

  task automatic test_bksp();
    send_word(16'hE071);
    send_word(16'h0016);
    send_word(16'h001E);
    send_word(16'h0066);
    check_buf("bksp1");
    send_word(16'h0000);
    send_word(16'h0066);
    send_word(16'h0000);
    send_word(16'h0066);
    send_word(16'hE071);
    check_buf("bksp_clear");
  endtask

  task automatic test_hold();
    int pulses = 0;
    send_word(16'h001C);
    repeat (100) begin
      @(posedge CLK_20M); #1;
      if (o_upd === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL hold extra upd pulses: got %0d expected 0", pulses);
    end
    check_buf("hold");
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 2: w = {8'h00, letter_codes[$urandom_range(0, 25)]};
        3, 4:    w = {8'h00, digit_codes[$urandom_range(0, 9)]};
        5:       w = 16'h0029;
        6:       w = 16'h0066;
        7:       w = 16'h0058;
        8:       w = ($urandom_range(0, 1) != 0) ? 16'hE071 : 16'h005A;
        9:       w = 16'h0000;
        10:      w = {8'hE0, 8'($urandom)};
        default: w = {8'h00, 8'($urandom)};
      endcase
      send_word(w);
      if (n % 20 == 19) check_buf("random");
    end
  endtask

  task automatic test_reset_mid();
    send_word(16'h0016);
    @(posedge CLK_20M); #1;
    i_ps2_data = 16'h001E;
    @(posedge CLK_20M); #1;
    RST_N = 0;
    #1;
    n_checks++;
    if (o_rd_char !== 8'h00 || o_cursor !== 5'd0 || o_caps !== 1'b0 || o_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL mid reset: got rd=%h cur=%0d caps=%b upd=%b expected zeros",
               o_rd_char, o_cursor, o_caps, o_upd);
    end
    i_ps2_data = 16'h0000;
    model_reset();
    repeat (3) @(posedge CLK_20M);
    #1;
    RST_N = 1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK_20M); #1;
      n_checks++;
      if (o_upd !== 1'b0 || o_cursor !== 5'd0) begin
        n_fail++;
        $display("FAIL post reset: got upd=%b cur=%0d expected 0/0", o_upd, o_cursor);
      end
    end
    check_buf("mid_reset");
  endtask

  initial begin
    test_reset();
    test_print();
    test_caps();
    test_full();
    test_bksp();
    test_hold();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
